// File: rtl/damage_pkg.sv
// Shared types and widths for the damage scheduler and its contact filters.
package damage_pkg;
   typedef enum logic [1:0] {PLAY, INVULN, DYING, OVER} state_t;

   localparam int CNT_W     = 7;
   localparam int TIMER_W   = 8;
   localparam int LIVES_W   = 2;
   localparam int SRC_IDX_W = 3;
endpackage

// File: rtl/damage_scheduler_if.sv
// Frame sync, hazard contacts and player-damage status exchanged with the scheduler.
interface damage_scheduler_if #(parameter int NUM_SRC = 4);
   import damage_pkg::*;

   logic                 vsync;
   logic [NUM_SRC-1:0]   hazard;
   logic                 restart;
   logic                 player_hurt;
   logic [SRC_IDX_W-1:0] hit_src;
   logic [LIVES_W-1:0]   lives;
   logic                 invulnerable;
   logic                 dying;
   logic                 game_over;

   modport master (output vsync, hazard, restart,
                   input  player_hurt, hit_src, lives, invulnerable, dying, game_over);
   modport slave  (input  vsync, hazard, restart,
                   output player_hurt, hit_src, lives, invulnerable, dying, game_over);
endinterface

// File: rtl/damage_scheduler_contact_filter.sv
// Per-source contact debouncer: a source is ripe once it has touched the player
// for HIT_TOLERANCE consecutive frame ticks and is still touching.
module contact_filter
   import damage_pkg::*;
#(
   parameter int HIT_TOLERANCE = 60
) (
   input  logic clk,
   input  logic reset_n,
   input  logic tick,
   input  logic hazard_i,
   input  logic clear,
   output logic ripe
);
   localparam logic [CNT_W-1:0] TOL = CNT_W'(HIT_TOLERANCE);

   logic [CNT_W-1:0] cnt;

   assign ripe = tick & hazard_i & (cnt == TOL);

   // Saturates at TOL so a held contact stays ripe on every tick.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)      cnt <= '0;
      else if (clear)    cnt <= '0;
      else if (tick) begin
         if (!hazard_i)  cnt <= '0;
         else if (cnt < TOL) cnt <= cnt + 1'b1;
      end
   end
endmodule

// File: rtl/damage_scheduler.sv
// Arbitrates filtered hazard contacts into hits, owns the lives count and runs
// the invulnerability, dying and game-over/restart sequence on frame ticks.
module damage_scheduler
   import damage_pkg::*;
#(
   parameter int NUM_SRC         = 4,
   parameter int HIT_TOLERANCE   = 60,
   parameter int INVULN_FRAMES   = 90,
   parameter int START_LIVES     = 3,
   parameter int GAMEOVER_FRAMES = 120
) (
   input  logic               clk,
   input  logic               reset_n,
   damage_scheduler_if.slave  bus
);
   localparam logic [LIVES_W-1:0] LIVES_INIT = LIVES_W'(START_LIVES);
   localparam logic [TIMER_W-1:0] T_INVULN   = TIMER_W'(INVULN_FRAMES);
   localparam logic [TIMER_W-1:0] T_DYING    = TIMER_W'(GAMEOVER_FRAMES);
   localparam logic [TIMER_W-1:0] T_ONE      = TIMER_W'(1);

   state_t               state, state_nx;
   logic [TIMER_W-1:0]   timer, timer_nx;
   logic [LIVES_W-1:0]   lives, lives_nx;
   logic [SRC_IDX_W-1:0] hit_src, hit_src_nx, win_idx;
   logic                 hurt_nx, player_hurt, inv_q, dying_q, over_q;
   logic                 vsync_q, tick, hit, clear;
   logic [NUM_SRC-1:0]   ripe;

   assign tick  = bus.vsync & ~vsync_q;
   assign hit   = (state == PLAY) && (|ripe) && (lives != '0);
   assign clear = (state != PLAY) || hit;

   for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
      contact_filter #(.HIT_TOLERANCE(HIT_TOLERANCE)) u_cf (
         .clk      (clk),
         .reset_n  (reset_n),
         .tick     (tick),
         .hazard_i (bus.hazard[g]),
         .clear    (clear),
         .ripe     (ripe[g])
      );
   end

   // Descending scan so the lowest ripe index is the last one written.
   always_comb begin
      win_idx = '0;
      for (int i = NUM_SRC - 1; i >= 0; i--)
         if (ripe[i]) win_idx = SRC_IDX_W'(i);
   end

   always_comb begin
      state_nx   = state;
      timer_nx   = timer;
      lives_nx   = lives;
      hit_src_nx = hit_src;
      hurt_nx    = 1'b0;
      case (state)
         PLAY: if (hit) begin
            hurt_nx    = 1'b1;
            hit_src_nx = win_idx;
            lives_nx   = lives - 1'b1;
            if (lives == LIVES_W'(1)) begin
               state_nx = DYING;
               timer_nx = T_DYING;
            end else begin
               state_nx = INVULN;
               timer_nx = T_INVULN;
            end
         end
         INVULN: if (tick) begin
            timer_nx = timer - 1'b1;
            if (timer <= T_ONE) state_nx = PLAY;
         end
         DYING: if (tick) begin
            timer_nx = timer - 1'b1;
            if (timer <= T_ONE) state_nx = OVER;
         end
         OVER: if (bus.restart) begin
            state_nx = PLAY;
            lives_nx = LIVES_INIT;
            timer_nx = '0;
         end
         default: state_nx = PLAY;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state       <= PLAY;
         timer       <= '0;
         lives       <= LIVES_INIT;
         hit_src     <= '0;
         player_hurt <= 1'b0;
         vsync_q     <= 1'b0;
         inv_q       <= 1'b0;
         dying_q     <= 1'b0;
         over_q      <= 1'b0;
      end else begin
         state       <= state_nx;
         timer       <= timer_nx;
         lives       <= lives_nx;
         hit_src     <= hit_src_nx;
         player_hurt <= hurt_nx;
         vsync_q     <= bus.vsync;
         inv_q       <= (state_nx == INVULN);
         dying_q     <= (state_nx == DYING);
         over_q      <= (state_nx == OVER);
      end
   end

   assign bus.player_hurt  = player_hurt;
   assign bus.hit_src      = hit_src;
   assign bus.lives        = lives;
   assign bus.invulnerable = inv_q;
   assign bus.dying        = dying_q;
   assign bus.game_over    = over_q;
endmodule

// File: tb/tb_damage_scheduler.sv
// Directed bench: expected hits go into a scoreboard queue that a monitor drains
// on every player_hurt pulse; status flags are checked at chosen frames.
module tb_damage_scheduler;
   import damage_pkg::*;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   always #5 clk = ~clk;

   damage_scheduler_if #(.NUM_SRC(4)) bus ();

   damage_scheduler #(
      .NUM_SRC(4), .HIT_TOLERANCE(3), .INVULN_FRAMES(90),
      .START_LIVES(3), .GAMEOVER_FRAMES(120)
   ) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   typedef struct {int src; int lives;} hit_t;
   hit_t exp_q[$];
   int n_pass = 0;
   int n_total = 0;

   task automatic chk(input string nm, input int act, input int exp);
      n_total++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
   endtask

   // Scoreboard monitor: every hurt pulse must match the oldest expected hit.
   initial forever begin
      @(negedge clk);
      if (reset_n && bus.player_hurt === 1'b1) begin
         if (exp_q.size() == 0) chk("unexpected_hurt", 1, 0);
         else begin
            hit_t e;
            e = exp_q.pop_front();
            chk("hit_src", int'(bus.hit_src), e.src);
            chk("hit_lives", int'(bus.lives), e.lives);
         end
      end
   end

   task automatic frame();
      @(posedge clk); #1 bus.vsync = 1'b1;
      @(posedge clk); #1 bus.vsync = 1'b0;
      repeat (2) @(posedge clk);
   endtask

   task automatic frames(input int n);
      repeat (n) frame();
   endtask

   task automatic expect_hit(input int s, input int l);
      hit_t e;
      e.src = s;
      e.lives = l;
      exp_q.push_back(e);
   endtask

   task automatic status(input string nm, input int l, input int inv, input int dy, input int ov);
      @(negedge clk);
      chk({nm, ".lives"}, int'(bus.lives), l);
      chk({nm, ".invulnerable"}, int'(bus.invulnerable), inv);
      chk({nm, ".dying"}, int'(bus.dying), dy);
      chk({nm, ".game_over"}, int'(bus.game_over), ov);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.vsync = 1'b0; bus.hazard = '0; bus.restart = 1'b0;
      repeat (3) @(posedge clk);
      #1 reset_n = 1'b1;
      status("reset", 3, 0, 0, 0);
      chk("reset.hit_src", int'(bus.hit_src), 0);
      chk("reset.player_hurt", int'(bus.player_hurt), 0);

      // Source 2 held: hit on the 4th tick; hazards ignored while invulnerable.
      bus.hazard = 4'b0100;
      frames(3);
      status("tol_pre_hit", 3, 0, 0, 0);
      expect_hit(2, 2);
      frame();
      status("hit1", 2, 1, 0, 0);
      bus.hazard = 4'b0001;
      frames(89);
      status("invuln_last", 2, 1, 0, 0);
      frame();
      status("invuln_done", 2, 0, 0, 0);
      bus.hazard = '0;

      // Contact broken on the 3rd tick restarts the count.
      bus.hazard = 4'b0010;
      frames(2);
      bus.hazard = '0;
      frame();
      bus.hazard = 4'b0010;
      frames(3);
      status("drop_no_hit", 2, 0, 0, 0);
      expect_hit(1, 1);
      frame();
      status("hit2", 1, 1, 0, 0);
      bus.hazard = '0;
      frames(90);
      status("invuln2_done", 1, 0, 0, 0);

      // Sources 1 and 3 ripe together: one fatal hit reporting source 1.
      bus.hazard = 4'b1010;
      frames(3);
      expect_hit(1, 0);
      frame();
      status("hit3_dying", 0, 0, 1, 0);
      bus.hazard = 4'b1111;
      frames(119);
      status("dying_last", 0, 0, 1, 0);
      frame();
      status("over", 0, 0, 0, 1);
      frames(3);
      status("over_hold", 0, 0, 0, 1);

      // Restart coinciding with a tick: counters must not advance that frame.
      bus.hazard = 4'b1000;
      @(posedge clk); #1 bus.vsync = 1'b1; bus.restart = 1'b1;
      @(posedge clk); #1 bus.vsync = 1'b0; bus.restart = 1'b0;
      status("restart", 3, 0, 0, 0);
      chk("restart.hit_src_held", int'(bus.hit_src), 1);
      frames(3);
      status("restart_no_early_hit", 3, 0, 0, 0);
      expect_hit(3, 2);
      frame();
      status("hit_after_restart", 2, 1, 0, 0);

      // Reset during invulnerability with 40 frames remaining.
      frames(50);
      @(posedge clk); #2 reset_n = 1'b0;
      #1;
      chk("midreset.lives", int'(bus.lives), 3);
      chk("midreset.invulnerable", int'(bus.invulnerable), 0);
      chk("midreset.player_hurt", int'(bus.player_hurt), 0);

      // vsync high out of reset and held: exactly one tick; restart in PLAY ignored.
      bus.hazard = 4'b0001;
      bus.vsync = 1'b1;
      @(posedge clk); #1 reset_n = 1'b1;
      repeat (4) @(posedge clk);
      #1 bus.restart = 1'b1;
      @(posedge clk); #1 bus.restart = 1'b0;
      repeat (5) @(posedge clk);
      #1 bus.vsync = 1'b0;
      status("vsync_hold", 3, 0, 0, 0);
      frames(2);
      status("vsync_no_early_hit", 3, 0, 0, 0);
      expect_hit(0, 2);
      frame();
      status("hit_vsync", 2, 1, 0, 0);
      bus.hazard = '0;

      repeat (5) @(posedge clk);
      @(negedge clk);
      chk("scoreboard_drained", exp_q.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule

// File: doc/damage_scheduler.md
# damage_scheduler

Frame-synchronised controller that arbitrates hazard contacts from several game objects into the player-damage resource: per-source contact filtering, lowest-index priority on simultaneous hits, life accounting, post-hit invulnerability and a game-over/restart sequence. Sits between the collision detectors and the HUD/heart renderer, replacing ad-hoc per-hazard damage logic with one scheduler that owns the lives count.

## Interface
- NUM_SRC, 4, number of hazard sources (1..8)
- HIT_TOLERANCE, 60, consecutive contact frames before a source deals damage (0..127)
- INVULN_FRAMES, 90, frames of invulnerability after a non-fatal hit (1..255)
- START_LIVES, 3, lives loaded at reset and restart (1..3)
- GAMEOVER_FRAMES, 120, frames spent in dying sequence before game over (1..255)

- clk  in  1  system clock; the only clock
- reset_n  in  1  asynchronous, active-low reset
- vsync  in  1  frame sync, synchronous to clk; rising edge = frame tick
- hazard  in  NUM_SRC  per-source contact with player, level, sampled only on frame tick
- restart  in  1  restart request, level, honoured only in OVER
- player_hurt  out  1  one-cycle pulse when a hit is applied
- hit_src  out  3  index of source that caused the last hit; holds until next hit
- lives  out  2  remaining lives
- invulnerable  out  1  high in INVULN
- dying  out  1  high in DYING
- game_over  out  1  high in OVER

## Operation
- Frame tick: tick = vsync & ~vsync_q, vsync_q registered every cycle; all frame-based behaviour advances only on tick cycles.
- Contact filter per source i: 7-bit counter cnt[i]. On tick: hazard[i]=0 -> cnt[i]=0; hazard[i]=1 and cnt[i]<HIT_TOLERANCE -> cnt[i]+1; else hold. Source ripe on a tick when hazard[i]=1 and cnt[i]==HIT_TOLERANCE (HIT_TOLERANCE=0: ripe on first contact tick).
- Counters update only in PLAY; forced to 0 in all other states.
- FSM states PLAY, INVULN, DYING, OVER; reset state PLAY.
- PLAY, tick, any source ripe: lowest ripe index wins; player_hurt pulse, hit_src=index, lives-1, all cnt cleared. New lives==0 -> DYING (timer=GAMEOVER_FRAMES) else INVULN (timer=INVULN_FRAMES).
- INVULN: timer decrements per tick; tick with timer==1 -> PLAY. Hazards ignored.
- DYING: timer decrements per tick; tick with timer==1 -> OVER.
- OVER: restart=1 on any cycle -> PLAY, lives=START_LIVES, timer=0, hit_src held.
- restart outside OVER ignored. Lives never underflow; no hit is possible while lives==0.

## Timing
- Reset values: player_hurt=0, hit_src=0, lives=START_LIVES, invulnerable=0, dying=0, game_over=0, all cnt=0, vsync_q=0, timer=0.
- All outputs registered; state/lives/hit_src/player_hurt change on the clock edge ending the tick cycle, visible one cycle after tick.
- player_hurt high exactly one cycle per hit; at most one hit per frame.
- vsync held high does not re-tick; vsync high out of reset generates a tick on the first cycle (vsync_q resets to 0).
- Simultaneous ripe sources: one hit only, lowest index reported; all other counters also cleared.
- reset_n asserted mid-INVULN/DYING: immediate return to reset values, no pulse.
- restart and tick in same OVER cycle: restart wins, counters stay 0 that frame.

## Structure
- Package damage_pkg: state enum (PLAY, INVULN, DYING, OVER, 2-bit), CNT_W=7, TIMER_W=8, LIVES_W=2, SRC_IDX_W=3.
- Sub-module contact_filter: one per source via generate; inputs clk, reset_n, tick, hazard_i, clear; outputs ripe. Scheduler holds FSM, priority encoder, lives and timer.

## Test plan
- HIT_TOLERANCE=3, hazard[2] held from frame 0 -> player_hurt on 4th tick, hit_src=2, lives 3->2, invulnerable=1 for 90 ticks then 0.
- hazard[1] dropped on 3rd tick then reasserted -> count restarts; hit only after 4 further consecutive contact ticks.
- hazard[3] and hazard[1] ripe same tick -> single pulse, hit_src=1, lives-1, no hit on following tick.
- Three hits -> lives 0, dying=1 for 120 ticks, then game_over=1; hazards ignored; restart -> lives=3, PLAY next cycle.
- vsync held high 10 cycles -> exactly one tick; restart pulsed in PLAY -> no effect.
- reset_n low during INVULN (timer 40) -> invulnerable=0, lives=3 immediately, no player_hurt.
